// File: rtl/coa_pkg.sv
// Shared definitions for the bit-serial adder.
//   - state encoding of the serial_adder controller
//   - default operand width
package coa_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/FA.sv
// Single-bit full-adder cell, used as the bit slice of serial_adder.
// Ports:
//   a, b  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
module FA (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are latched on an accepted start and
// added LSB-first through one FA cell, one bit per clock, with a registered
// carry. {cout,sum} = a + b + cin is presented with a one-cycle done pulse.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : request, sampled only while not busy
//   a, b, cin  : operands, latched on the accepting edge
//   busy       : high while bits are being added
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result, held until the next completion
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | waiting for start
// RUN   | adding one bit per clock, cnt = bit index being added
// DONE  | result just written; start here chains the next add
module serial_adder
   import coa_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Only the upper WIDTH-1 bits of the sum shift register ever reach the
   // result; the newest bit comes straight from the FA on the final edge.
   logic [WIDTH-2:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_next;

   FA u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign sum_next = {fa_s, sum_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               sum_sr <= sum_next[WIDTH-1:1];
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= fa_co;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  sum   <= sum_next;
                  cout  <= fa_co;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       cin4 = 1'b0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   // Reference model: an accepted request makes the unit busy for WIDTH
   // cycles, after which the arithmetic sum appears with a one-cycle done.
   int         m8_left = 0;
   logic       m8_done = 1'b0;
   logic [7:0] m8_sum  = '0;
   logic       m8_cout = 1'b0;
   logic [8:0] m8_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m8_left <= 0; m8_done <= 1'b0; m8_sum <= '0; m8_cout <= 1'b0;
      end else if (m8_left == 0) begin
         m8_done <= 1'b0;
         if (start8) begin
            m8_pend <= 9'(a8) + 9'(b8) + 9'(cin8);
            m8_left <= 8;
         end
      end else begin
         m8_left <= m8_left - 1;
         if (m8_left == 1) begin
            m8_done <= 1'b1;
            {m8_cout, m8_sum} <= m8_pend;
         end
      end
   end

   int         m4_left = 0;
   logic       m4_done = 1'b0;
   logic [3:0] m4_sum  = '0;
   logic       m4_cout = 1'b0;
   logic [4:0] m4_pend = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m4_left <= 0; m4_done <= 1'b0; m4_sum <= '0; m4_cout <= 1'b0;
      end else if (m4_left == 0) begin
         m4_done <= 1'b0;
         if (start4) begin
            m4_pend <= 5'(a4) + 5'(b4) + 5'(cin4);
            m4_left <= 4;
         end
      end else begin
         m4_left <= m4_left - 1;
         if (m4_left == 1) begin
            m4_done <= 1'b1;
            {m4_cout, m4_sum} <= m4_pend;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy8", busy8, m8_left != 0);
      chk("done8", done8, m8_done);
      chk("sum8",  sum8,  m8_sum);
      chk("cout8", cout8, m8_cout);
      chk("busy4", busy4, m4_left != 0);
      chk("done4", done4, m4_done);
      chk("sum4",  sum4,  m4_sum);
      chk("cout4", cout4, m4_cout);
   end

   // One WIDTH=8 add; operands are scrambled after the accepting edge.
   // Returns at the negedge where done is visible.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [7:0] es, input logic ec, input string nm);
      int n;
      @(negedge clk);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
      n = 1;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_lat"}, n, 9);
      chk({nm, "_sum"}, sum8, es);
      chk({nm, "_cout"}, cout8, ec);
      chk({nm, "_model"}, {m8_cout, m8_sum}, {ec, es});
   endtask

   initial begin
      int n;
      int seen;
      logic [4:0] e4;

      repeat (2) @(negedge clk);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum",  sum8,  0);
      chk("rst_cout", cout8, 0);
      rst = 1'b0;

      run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
      run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
      run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

      // start while busy is ignored
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
         start8 = (n == 3);
         if (n == 3) begin
            a8 = 8'hAA; b8 = 8'h55;
         end
      end
      start8 = 1'b0;
      chk("ign_lat", n, 9);
      chk("ign_sum", sum8, 8'h30);
      chk("ign_cout", cout8, 0);

      // back-to-back: chain from the done cycle
      run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "b2b_first");
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 1;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat", n, 9);
      chk("b2b_sum", sum8, 8'h00);
      chk("b2b_cout", cout8, 1);

      // reset in the middle of an operation
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy8, 0);
      chk("mid_rst_done", done8, 0);
      chk("mid_rst_sum",  sum8,  0);
      chk("mid_rst_cout", cout8, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8) seen++;
      end
      chk("mid_rst_no_done", seen, 0);
      run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "after_rst");

      // WIDTH=4 exhaustive
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         n = 1;
         while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
         end
         e4 = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
         chk("x4_lat", n, 5);
         chk("x4_res", {cout4, sum4}, e4);
         @(negedge clk);
         chk("x4_pulse", done4, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing single-bit full-adder cell `FA`, plus a registered carry.
- Operands are latched on a start strobe and processed LSB-first, one bit per clock.
- The result is presented with a one-cycle done pulse.
- It is the sequential stage directly downstream of the full-adder cell: it consumes `FA`'s `s`/`co` every cycle. It is the datapath adder for the course multi-cycle ALU.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk    input   1      single clock, rising-edge.
- rst    input   1      asynchronous, active-high reset.
- start  input   1      request; sampled only when busy=0.
- a      input   WIDTH  operand A; latched on accepted start.
- b      input   WIDTH  operand B; latched on accepted start.
- cin    input   1      carry-in; latched on accepted start.
- busy   output  1      high while bits are being added.
- done   output  1      one-cycle pulse: sum/cout valid.
- sum    output  WIDTH  registered result; held until next completion.
- cout   output  1      registered carry-out; held with sum.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0; internal shift registers, carry and bit counter all 0.
- FSM states: IDLE, RUN, DONE. Moore outputs: busy=(state==RUN), done=(state==DONE).
- IDLE, start=1:
  - load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - `FA` inputs are A_sr[0], B_sr[0], carry.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}; A_sr, B_sr shift right by 1 (zero fill); carry<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1: additionally sum<={s, sum_sr[WIDTH-1:1]}, cout<=co, go to DONE.
- DONE: lasts exactly one cycle.
  - start=1: load as in IDLE and go to RUN (back-to-back ops, no bubble).
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high between edges E(WIDTH) and E(WIDTH+1). Throughput is one add per WIDTH+1 cycles.
- start while busy=1: ignored. The in-flight operation and its latched operands are unaffected.
- Changes on a/b/cin after the accepting edge have no effect.
- sum/cout change only on the completing edge; they hold the previous result during RUN, IDLE and DONE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt is $clog2(WIDTH) bits wide; it never wraps within an operation.
- Reset mid-operation (any state): immediate return to reset values; the partial result is discarded; no done pulse.
- start asserted in the same cycle reset deasserts: not accepted until the first edge with rst=0.

Decomposition:
- Shared package coa_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- One sub-module: the existing `FA` cell (ports a, b, ci, s, co), instantiated once as the bit slice.
- FSM, counter and shift registers live in serial_adder.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start 1 cycle -> busy for 8 cycles; done pulses on the 8th edge after start; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x10+0x20; at cycle 3 drive start=1 with a=0xAA, b=0x55 -> ignored; result sum=0x30, cout=0 at the original done time.
- Back-to-back: 0x01+0x02 is done; start held high in the DONE cycle with 0x80+0x80 -> sum=0x03 on the first done, and the second done exactly 9 cycles later with sum=0x00, cout=1.
- Assert rst at cycle 4 of 0x7F+0x01 -> busy, done, sum, cout go to 0 immediately; no done pulse; a subsequent 0x7F+0x01 gives sum=0x80.
- WIDTH=4 exhaustive: all 512 (a, b, cin) combinations -> {cout,sum} equals a+b+cin; done is exactly one cycle per op.
